pipe_ctrl: RTL

Central sequencing controller for the 5-stage pipeline (IF, ID, EX, MEM, WB). It drives the PC and the four pipeline-register write enables and flushes, and the PCSrc select. It detects load-use hazards, resolves taken branches in MEM, and freezes the pipeline while the data memory holds off an access. It also keeps saturating stall/flush statistics and a sticky memory-timeout error.

---
 rtl/pipe_ctrl_pkg.sv | 44 ++++
 rtl/pipe_ctrl_sat_counter.sv | 42 ++++
 rtl/pipe_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline sequencing
// controller and the datapath that consumes its control bundle.
//   state_e      : controller states (BOOT, RUN, MEM_WAIT, ERR)
//   REG_ZERO     : architectural register $0, never a real hazard source
//   pipe_ctrl_t  : PC enable plus the seven pipeline-register enable/flush bits
//   ctrl_uniform : builds a bundle with every stage enable / flush alike
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERR      = 2'd3
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic id_ex_we;
    logic ex_mem_we;
    logic mem_wb_we;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
  } pipe_ctrl_t;

  function automatic pipe_ctrl_t ctrl_uniform(input logic pc_en,
                                              input logic stage_en,
                                              input logic flush);
    pipe_ctrl_t c;
    c.pc_we        = pc_en;
    c.if_id_we     = stage_en;
    c.id_ex_we     = stage_en;
    c.ex_mem_we    = stage_en;
    c.mem_wb_we    = stage_en;
    c.if_id_flush  = flush;
    c.id_ex_flush  = flush;
    c.ex_mem_flush = flush;
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// sat_counter: W-bit event counter that sticks at all-ones instead of wrapping.
//   clk, rst_n : clock and asynchronous active-low reset (clears count)
//   inc        : count one event this cycle
//   clear      : synchronous clear, wins over inc
//   count      : current registered count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = {W{1'b0}};
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: sequencing controller for the 5-stage pipeline.
// Drives PC enable/select and the IF/ID, ID/EX, EX/MEM, MEM/WB enables and
// flushes. Control outputs are Mealy (same-cycle) so the pipeline registers
// act on the very edge that ends the cycle in which a condition is seen.
//   CLK, RST          : clock, asynchronous active-low reset
//   id_rs/id_rt/...   : hazard inputs from ID and EX
//   mem_branch/zero   : branch resolution in MEM
//   mem_req/dm_ready  : data-memory handshake
//   pc_we, pc_src, *_we, *_flush : pipeline control
//   err_timeout       : sticky data-memory timeout
//   stall_cnt, flush_cnt : saturating statistics
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 64
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             mem_branch,
  input  logic             mem_zero,
  input  logic             mem_req,
  input  logic             dm_ready,
  output logic             pc_we,
  output logic             pc_src,
  output logic             if_id_we,
  output logic             id_ex_we,
  output logic             ex_mem_we,
  output logic             mem_wb_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             err_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WAIT_MAX);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [WAIT_W-1:0] wait_nxt_s;
  logic              err_q, err_d;

  pipe_ctrl_t        ctrl_s;
  logic              pc_src_s;
  logic              br_taken_s;
  logic              load_use_s;
  logic              hold_off_s;
  logic              stall_inc_s;

  assign br_taken_s = mem_branch & mem_zero;
  // A load writing $0 never creates a real dependency.
  assign load_use_s = ex_mem_read & (ex_rt != REG_ZERO) &
                      ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  // dm_ready only matters while an access is actually outstanding.
  assign hold_off_s = mem_req & ~dm_ready;

  // Next-state, wait counter, error flag and Mealy control outputs.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    wait_nxt_s = wait_cnt_q;
    err_d      = err_q;
    ctrl_s     = ctrl_uniform(1'b1, 1'b1, 1'b0);
    pc_src_s   = 1'b0;
    case (state_q)
      ST_BOOT: begin
        // Clear every pipeline register once, hold the PC.
        ctrl_s     = ctrl_uniform(1'b0, 1'b1, 1'b1);
        state_d    = ST_RUN;
        wait_cnt_d = {WAIT_W{1'b0}};
      end
      ST_RUN, ST_MEM_WAIT: begin
        if (hold_off_s) begin
          // Freeze; load-use and branches wait until memory releases.
          ctrl_s     = ctrl_uniform(1'b0, 1'b0, 1'b0);
          wait_nxt_s = (state_q == ST_RUN) ? WAIT_W'(1) : (wait_cnt_q + WAIT_W'(1));
          wait_cnt_d = wait_nxt_s;
          if (wait_nxt_s >= WAIT_LIMIT) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = ST_MEM_WAIT;
          end
        end else begin
          state_d    = ST_RUN;
          wait_cnt_d = {WAIT_W{1'b0}};
          if (br_taken_s) begin
            // The dependent instruction is squashed, so load-use is moot.
            pc_src_s = 1'b1;
            ctrl_s   = ctrl_uniform(1'b1, 1'b1, 1'b1);
          end else if (load_use_s) begin
            ctrl_s             = ctrl_uniform(1'b1, 1'b1, 1'b0);
            ctrl_s.pc_we       = 1'b0;
            ctrl_s.if_id_we    = 1'b0;
            ctrl_s.id_ex_flush = 1'b1;
          end else begin
            ctrl_s = ctrl_uniform(1'b1, 1'b1, 1'b0);
          end
        end
      end
      ST_ERR: begin
        ctrl_s  = ctrl_uniform(1'b0, 1'b0, 1'b0);
        state_d = ST_ERR;
      end
      default: begin
        ctrl_s  = ctrl_uniform(1'b0, 1'b1, 1'b1);
        state_d = ST_BOOT;
      end
    endcase
  end

  // State, wait counter and sticky error registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_BOOT;
      wait_cnt_q <= {WAIT_W{1'b0}};
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  // BOOT's PC hold is initialisation, not a stall.
  assign stall_inc_s = (state_q != ST_BOOT) & ~ctrl_s.pc_we;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (CLK),
    .rst_n (RST),
    .inc   (stall_inc_s),
    .clear (1'b0),
    .count (stall_cnt)
  );

  // pc_src is only raised on an unfrozen taken branch.
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (CLK),
    .rst_n (RST),
    .inc   (pc_src_s),
    .clear (1'b0),
    .count (flush_cnt)
  );

  assign pc_we        = ctrl_s.pc_we;
  assign pc_src       = pc_src_s;
  assign if_id_we     = ctrl_s.if_id_we;
  assign id_ex_we     = ctrl_s.id_ex_we;
  assign ex_mem_we    = ctrl_s.ex_mem_we;
  assign mem_wb_we    = ctrl_s.mem_wb_we;
  assign if_id_flush  = ctrl_s.if_id_flush;
  assign id_ex_flush  = ctrl_s.id_ex_flush;
  assign ex_mem_flush = ctrl_s.ex_mem_flush;
  assign err_timeout  = err_q;

endmodule
